// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 filter window master.
package filter_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MRD,
        S_MWAIT,
        S_FWR,
        S_GAP,
        S_FRD,
        S_MWR,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int         FLT_WIN       = 9;
    localparam logic [3:0] FLT_PIX_FIRST = 4'd0;
    localparam logic [3:0] FLT_PIX_LAST  = 4'(FLT_WIN - 1);
    localparam int         PIX_STRIDE    = 4;

endpackage

// File: rtl/window_addr_gen.sv
// Incremental x/y and pixel-index counters for the interior 3x3 window scan.
module window_addr_gen
    import filter_pkg::*;
#(
    parameter int DIM_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_init,
    input  logic               i_step,
    input  logic               i_next_out,
    input  logic [DIM_W-1:0]   i_img_w,
    input  logic [DIM_W-1:0]   i_img_h,
    output logic [2*DIM_W-1:0] o_win_idx,
    output logic [2*DIM_W-1:0] o_out_idx,
    output logic [3:0]         o_win_pos,
    output logic               o_last_in_window,
    output logic               o_last_output
);
    localparam int IW = 2 * DIM_W;

    logic [DIM_W-1:0] r_x;
    logic [DIM_W-1:0] r_y;
    logic [IW-1:0]    r_row_base;
    logic [IW-1:0]    r_win_start;
    logic [IW-1:0]    r_win_idx;
    logic [1:0]       r_col;
    logic [3:0]       r_pos;
    logic [IW-1:0]    w_img_w;
    logic             w_last_col;

    assign w_img_w    = IW'(i_img_w);
    assign w_last_col = (r_x == i_img_w - DIM_W'(2));

    // r_row_base tracks (y-1)*img_w; r_win_start is the top-left index of the window
    always_ff @(posedge clk) begin
        if (reset || i_init) begin
            r_x         <= DIM_W'(1);
            r_y         <= DIM_W'(1);
            r_row_base  <= '0;
            r_win_start <= '0;
            r_win_idx   <= '0;
            r_col       <= '0;
            r_pos       <= FLT_PIX_FIRST;
        end else if (i_step) begin
            r_pos <= r_pos + 4'd1;
            if (r_col == 2'd2) begin
                r_col     <= '0;
                r_win_idx <= r_win_idx + w_img_w - IW'(2);
            end else begin
                r_col     <= r_col + 2'd1;
                r_win_idx <= r_win_idx + IW'(1);
            end
        end else if (i_next_out) begin
            r_pos <= FLT_PIX_FIRST;
            r_col <= '0;
            if (w_last_col) begin
                r_x         <= DIM_W'(1);
                r_y         <= r_y + DIM_W'(1);
                r_row_base  <= r_row_base + w_img_w;
                r_win_start <= r_row_base + w_img_w;
                r_win_idx   <= r_row_base + w_img_w;
            end else begin
                r_x         <= r_x + DIM_W'(1);
                r_win_start <= r_win_start + IW'(1);
                r_win_idx   <= r_win_start + IW'(1);
            end
        end
    end

    assign o_win_idx        = r_win_idx;
    assign o_out_idx        = r_win_start + w_img_w + IW'(1);
    assign o_win_pos        = r_pos;
    assign o_last_in_window = (r_pos == FLT_PIX_LAST);
    assign o_last_output    = w_last_col && (r_y == i_img_h - DIM_W'(2));

endmodule

// File: rtl/filter_window_master.sv
// Avalon-MM initiator: gathers each interior 3x3 source window, pushes it through
// the filter slave and writes the 8-bit result to the destination buffer.
//   state   | meaning
//   IDLE    | waiting for start
//   MRD     | memory read of the current window pixel
//   MWAIT   | waiting for memory readdatavalid
//   FWR     | write pixel to filter address k
//   GAP     | let the filter pipeline settle
//   FRD     | read filtered result
//   MWR     | write result to destination
//   NEXT    | advance to next output or finish
//   DONE    | one-cycle done pulse
module filter_window_master
    import filter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 12,
    parameter int FLT_GAP = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    input  logic [DIM_W-1:0]   img_w,
    input  logic [DIM_W-1:0]   img_h,
    output logic               busy,
    output logic               done,
    output logic [2*DIM_W-1:0] pix_count,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_read,
    input  logic [31:0]        mem_readdata,
    input  logic               mem_readdatavalid,
    output logic               mem_write,
    output logic [31:0]        mem_writedata,
    input  logic               mem_waitrequest,
    output logic [3:0]         flt_address,
    output logic               flt_read,
    input  logic [31:0]        flt_readdata,
    output logic               flt_write,
    output logic [31:0]        flt_writedata,
    input  logic               flt_waitrequest
);
    localparam int IW    = 2 * DIM_W;
    localparam int GAP_W = (FLT_GAP > 1) ? $clog2(FLT_GAP) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_src_base;
    logic [ADDR_W-1:0]  r_dst_base;
    logic [DIM_W-1:0]   r_img_w;
    logic [DIM_W-1:0]   r_img_h;
    logic               r_small;
    logic [23:0]        r_word;
    logic [7:0]         r_result;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [IW-1:0]      r_pix_count;

    logic               w_start_small;
    logic               w_init;
    logic               w_step;
    logic               w_next_out;
    logic [IW-1:0]      w_win_idx;
    logic [IW-1:0]      w_out_idx;
    logic [3:0]         w_win_pos;
    logic               w_last_in_window;
    logic               w_last_output;
    logic [ADDR_W-1:0]  w_src_addr;
    logic [ADDR_W-1:0]  w_dst_addr;
    logic               w_unused;

    assign w_unused      = ^{mem_readdata[31:24], flt_readdata[31:8]};
    assign w_start_small = (img_w < DIM_W'(3)) || (img_h < DIM_W'(3));
    assign w_init        = (r_state == S_IDLE) && start;
    assign w_step        = (r_state == S_FWR) && !flt_waitrequest && !w_last_in_window;
    assign w_next_out    = (r_state == S_NEXT);
    assign w_src_addr    = r_src_base + ADDR_W'(w_win_idx) * ADDR_W'(PIX_STRIDE);
    assign w_dst_addr    = r_dst_base + ADDR_W'(w_out_idx) * ADDR_W'(PIX_STRIDE);

    window_addr_gen #(
        .DIM_W (DIM_W)
    ) u_addr_gen (
        .clk              (clk),
        .reset            (reset),
        .i_init           (w_init),
        .i_step           (w_step),
        .i_next_out       (w_next_out),
        .i_img_w          (r_img_w),
        .i_img_h          (r_img_h),
        .o_win_idx        (w_win_idx),
        .o_out_idx        (w_out_idx),
        .o_win_pos        (w_win_pos),
        .o_last_in_window (w_last_in_window),
        .o_last_output    (w_last_output)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Degenerate images pass through NEXT so busy is seen for one cycle before done
    always_comb begin
        w_next_state  = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        flt_read      = 1'b0;
        flt_write     = 1'b0;
        flt_address   = '0;
        flt_writedata = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_start_small ? S_NEXT : S_MRD;
                end
            end
            S_MRD: begin
                mem_read    = 1'b1;
                mem_address = w_src_addr;
                if (!mem_waitrequest) begin
                    w_next_state = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (mem_readdatavalid) begin
                    w_next_state = S_FWR;
                end
            end
            S_FWR: begin
                flt_write     = 1'b1;
                flt_address   = w_win_pos;
                flt_writedata = {8'h00, r_word};
                if (!flt_waitrequest) begin
                    w_next_state = w_last_in_window ? S_GAP : S_MRD;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next_state = S_FRD;
                end
            end
            S_FRD: begin
                flt_read = 1'b1;
                if (!flt_waitrequest) begin
                    w_next_state = S_MWR;
                end
            end
            S_MWR: begin
                mem_write     = 1'b1;
                mem_address   = w_dst_addr;
                mem_writedata = {24'h0, r_result};
                if (!mem_waitrequest) begin
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next_state = (r_small || w_last_output) ? S_DONE : S_MRD;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_img_w     <= '0;
            r_img_h     <= '0;
            r_small     <= 1'b0;
            r_word      <= '0;
            r_result    <= '0;
            r_gap_cnt   <= '0;
            r_pix_count <= '0;
        end else begin
            if (w_init) begin
                r_src_base  <= src_base;
                r_dst_base  <= dst_base;
                r_img_w     <= img_w;
                r_img_h     <= img_h;
                r_small     <= w_start_small;
                r_pix_count <= '0;
            end
            if ((r_state == S_MWAIT) && mem_readdatavalid) begin
                r_word <= mem_readdata[23:0];
            end
            if ((r_state == S_FWR) && !flt_waitrequest && w_last_in_window) begin
                r_gap_cnt <= GAP_W'(FLT_GAP - 1);
            end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            if ((r_state == S_FRD) && !flt_waitrequest) begin
                r_result <= flt_readdata[7:0];
            end
            if ((r_state == S_MWR) && !mem_waitrequest) begin
                r_pix_count <= r_pix_count + IW'(1);
            end
        end
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign pix_count = r_pix_count;

endmodule

// File: tb/tb_filter_window_master.sv
// Directed bench for filter_window_master with Avalon memory and filter slave models.
module tb_filter_window_master;

    typedef struct {
        int          w;
        int          h;
        logic [31:0] src;
        logic [31:0] dst;
        bit          rnd;
        int          n;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [11:0] img_w;
    logic [11:0] img_h;
    logic        busy;
    logic        done;
    logic [23:0] pix_count;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [3:0]  flt_address;
    logic        flt_read;
    logic [31:0] flt_readdata;
    logic        flt_write;
    logic [31:0] flt_writedata;
    logic        flt_waitrequest;

    filter_window_master dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_base          (src_base),
        .dst_base          (dst_base),
        .img_w             (img_w),
        .img_h             (img_h),
        .busy              (busy),
        .done              (done),
        .pix_count         (pix_count),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .flt_address       (flt_address),
        .flt_read          (flt_read),
        .flt_readdata      (flt_readdata),
        .flt_write         (flt_write),
        .flt_writedata     (flt_writedata),
        .flt_waitrequest   (flt_waitrequest)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_q[$];
    logic [35:0] fw_q[$];
    logic [63:0] mw_q[$];
    int          frd_cnt, done_cnt, busy_cnt, stab_err, strobe_cnt;
    logic [31:0] m_src;
    bit          rnd;
    logic [31:0] fbuf [0:15];

    function automatic logic [31:0] pix(input logic [31:0] i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hC3, 8'(b * 8'd7 + 8'd1), 8'(b * 8'd13 + 8'd5), b ^ 8'h5A};
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave models and bus monitor; decisions are made at negedge for the next posedge
    initial begin : slaves
        bit          pend;
        int          lat_cnt;
        logic [31:0] pend_addr;
        bit          mw, fw, p_mstall, p_fstall;
        logic        p_mrd, p_mwr, p_frd, p_fwr;
        logic [31:0] p_maddr, p_mwd, p_fwd;
        logic [3:0]  p_faddr;
        logic [7:0]  fcs;
        pend = 0; lat_cnt = 0; pend_addr = 0; p_mstall = 0; p_fstall = 0;
        p_mrd = 0; p_mwr = 0; p_frd = 0; p_fwr = 0;
        p_maddr = 0; p_mwd = 0; p_fwd = 0; p_faddr = 0;
        mem_readdata = 32'h0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        flt_readdata = 32'h0; flt_waitrequest = 1'b0;
        for (int k = 0; k < 16; k++) fbuf[k] = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0;
                p_mstall = 0;
                p_fstall = 0;
                mem_readdatavalid = 1'b0;
                mem_waitrequest = 1'b0;
                flt_waitrequest = 1'b0;
            end else begin
                if (p_mstall && (mem_read !== p_mrd || mem_write !== p_mwr ||
                                 mem_address !== p_maddr || mem_writedata !== p_mwd))
                    stab_err++;
                if (p_fstall && (flt_read !== p_frd || flt_write !== p_fwr ||
                                 flt_address !== p_faddr || flt_writedata !== p_fwd))
                    stab_err++;
                if (busy) busy_cnt++;
                if (done) done_cnt++;
                if (mem_read || mem_write || flt_read || flt_write) strobe_cnt++;
                if (pend && lat_cnt == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = pix((pend_addr - m_src) >> 2);
                    pend = 0;
                end else begin
                    mem_readdatavalid = 1'b0;
                    mem_readdata = 32'h0BAD_F00D;
                    if (pend) lat_cnt--;
                end
                mw = rnd ? ($urandom_range(0, 9) < 4) : 1'b0;
                fw = rnd ? ($urandom_range(0, 9) < 4) : 1'b0;
                mem_waitrequest = mw;
                flt_waitrequest = fw;
                if (mem_read && !mw) begin
                    rd_q.push_back(mem_address);
                    pend = 1;
                    pend_addr = mem_address;
                    lat_cnt = (rnd ? int'($urandom_range(1, 5)) : 1) - 1;
                end
                if (mem_write && !mw) mw_q.push_back({mem_address, mem_writedata});
                if (flt_write && !fw) begin
                    fw_q.push_back({flt_address, flt_writedata});
                    fbuf[flt_address] = flt_writedata;
                end
                if (flt_read && !fw) frd_cnt++;
                fcs = 8'h0;
                for (int k = 0; k < 9; k++)
                    fcs = 8'(fcs + fbuf[k][7:0] + fbuf[k][15:8] + fbuf[k][23:16]);
                flt_readdata = {24'hDEADBE, fcs};
                p_mstall = (mem_read || mem_write) && mw;
                p_fstall = (flt_read || flt_write) && fw;
                p_mrd = mem_read; p_mwr = mem_write; p_maddr = mem_address; p_mwd = mem_writedata;
                p_frd = flt_read; p_fwr = flt_write; p_faddr = flt_address; p_fwd = flt_writedata;
            end
        end
    end

    task automatic clear_mon;
        rd_q.delete();
        fw_q.delete();
        mw_q.delete();
        frd_cnt = 0; done_cnt = 0; busy_cnt = 0; stab_err = 0; strobe_cnt = 0;
    endtask

    task automatic check_job(input vec_t v);
        int          bad_rd, bad_fw, bad_wr, ri, fi, wi;
        logic [7:0]  cs;
        logic [31:0] idx, d, ea;
        bad_rd = 0; bad_fw = 0; bad_wr = 0; ri = 0; fi = 0; wi = 0;
        for (int y = 1; y <= v.h - 2; y++) begin
            for (int x = 1; x <= v.w - 2; x++) begin
                cs = 8'h0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        idx = 32'((y - 1 + r) * v.w + (x - 1 + c));
                        d   = pix(idx);
                        ea  = v.src + idx * 32'd4;
                        if (ri >= rd_q.size() || rd_q[ri] !== ea) bad_rd++;
                        if (fi >= fw_q.size() || fw_q[fi] !== {4'(r * 3 + c), 8'h00, d[23:0]}) bad_fw++;
                        ri++; fi++;
                        cs = 8'(cs + d[7:0] + d[15:8] + d[23:16]);
                    end
                end
                ea = v.dst + 32'(y * v.w + x) * 32'd4;
                if (wi >= mw_q.size() || mw_q[wi] !== {ea, 24'h0, cs}) bad_wr++;
                wi++;
            end
        end
        chk("rd_count", rd_q.size(), v.n * 9);
        chk("rd_addr_seq", bad_rd, 0);
        chk("flt_wr_count", fw_q.size(), v.n * 9);
        chk("flt_wr_seq", bad_fw, 0);
        chk("flt_rd_count", frd_cnt, v.n);
        chk("mem_wr_count", mw_q.size(), v.n);
        chk("mem_wr_seq", bad_wr, 0);
        if (v.n > 0) begin
            chk("first_wr_addr", (mw_q.size() > 0) ? 64'(mw_q[0][63:32]) : 64'hFFFF_FFFF_FFFF, v.first);
            chk("last_wr_addr", (mw_q.size() > 0) ? 64'(mw_q[mw_q.size() - 1][63:32]) : 64'hFFFF_FFFF_FFFF, v.last);
        end else begin
            chk("no_strobes", strobe_cnt, 0);
            chk("busy_cycles", busy_cnt, 1);
        end
        chk("pix_count", pix_count, v.n);
        chk("done_pulses", done_cnt, 1);
        chk("stall_stable", stab_err, 0);
        chk("busy_end", busy, 0);
    endtask

    task automatic run_job(input vec_t v, input bit inject);
        bit timeout, injected;
        clear_mon();
        m_src = v.src;
        rnd = v.rnd;
        img_w = 12'(v.w);
        img_h = 12'(v.h);
        src_base = v.src;
        dst_base = v.dst;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        timeout = 1;
        injected = 0;
        for (int c = 0; c < 20000; c++) begin
            if (done_cnt > 0) begin
                timeout = 0;
                break;
            end
            if (inject && !injected && flt_read) begin
                start = 1'b1;
                img_w = 12'd3; img_h = 12'd3;
                src_base = 32'h5000; dst_base = 32'h6000;
                injected = 1;
            end
            tick;
            start = 1'b0;
        end
        chk("job_timeout", timeout, 0);
        if (inject) chk("start_injected", injected, 1);
        repeat (4) tick;
        check_job(v);
    endtask

    vec_t vecs[8];

    initial begin
        bit   timeout;
        vec_t v5;
        vecs[0] = '{3, 3, 32'h1000, 32'h2000, 1'b0, 1, 32'h2010, 32'h2010};
        vecs[1] = '{4, 3, 32'h1000, 32'h0, 1'b0, 2, 32'h14, 32'h18};
        vecs[2] = '{4, 3, 32'h1000, 32'h0, 1'b1, 2, 32'h14, 32'h18};
        vecs[3] = '{5, 5, 32'h3000, 32'h8000, 1'b1, 9, 32'h8018, 32'h8048};
        vecs[4] = '{2, 10, 32'h1000, 32'h2000, 1'b0, 0, 32'h0, 32'h0};
        vecs[5] = '{10, 2, 32'h1000, 32'h2000, 1'b1, 0, 32'h0, 32'h0};
        vecs[6] = '{3, 3, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1, 32'h0, 32'h0};
        vecs[7] = '{6, 4, 32'h400, 32'h10000, 1'b1, 8, 32'h1001C, 32'h10040};
        v5      = '{5, 5, 32'h3000, 32'h8000, 1'b0, 9, 32'h8018, 32'h8048};

        reset = 1'b1; start = 1'b0; src_base = 0; dst_base = 0; img_w = 0; img_h = 0;
        m_src = 0; rnd = 0;
        clear_mon();
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {mem_read, mem_write, flt_read, flt_write}, 0);
        chk("rst_addr", {mem_address, 28'h0, flt_address}, 0);
        chk("rst_wdata", {mem_writedata, flt_writedata}, 0);
        chk("rst_pix_count", pix_count, 0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) run_job(vecs[i], 1'b0);

        // reset during the filter gap of the second window of a 5x5 job
        clear_mon();
        m_src = v5.src; rnd = 0;
        img_w = 12'd5; img_h = 12'd5; src_base = v5.src; dst_base = v5.dst;
        start = 1'b1;
        tick;
        start = 1'b0;
        timeout = 1;
        for (int c = 0; c < 5000; c++) begin
            if (fw_q.size() >= 18) begin
                timeout = 0;
                break;
            end
            tick;
        end
        chk("reach_gap", timeout, 0);
        tick;
        chk("busy_in_gap", busy, 1);
        chk("pix_before_rst", pix_count, 1);
        reset = 1'b1;
        tick;
        chk("midrst_strobes", {mem_read, mem_write, flt_read, flt_write}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pix", pix_count, 0);
        reset = 1'b0;
        tick;
        run_job(v5, 1'b0);

        // start pulsed during FRD must be ignored
        run_job(vecs[1], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
